// File: rtl/limber_gnrl_rand_pack_pkg.sv
// Shared helpers for the random-word packer: width calculation, lane count
// and parameter legality checks.
package limber_gnrl_rand_pack_pkg;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // Counter width that is never zero, so a 1-state counter still has a bit.
  function automatic int unsigned width_f(input int unsigned n);
    return (clog2_f(n) == 0) ? 1 : clog2_f(n);
  endfunction

  function automatic int unsigned lanes_f(input int unsigned word_len,
                                          input int unsigned rand_len);
    return word_len / rand_len;
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit pack_params_ok(input int unsigned rand_len,
                                        input int unsigned word_len,
                                        input int unsigned decorr,
                                        input int unsigned fifo_depth);
    return (rand_len >= 1) && (word_len >= rand_len) &&
           ((word_len % rand_len) == 0) && (decorr >= 1) &&
           (fifo_depth >= 2) && is_pow2(fifo_depth);
  endfunction

endpackage

// File: rtl/limber_gnrl_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one wrap bit so
// full and empty are distinguished without a separate counter. The head word
// reads as zero while the FIFO is empty.
module limber_gnrl_fifo
  import limber_gnrl_rand_pack_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int unsigned AW   = clog2_f(DEPTH);
  localparam int unsigned LVLW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  // Status flags, head word and occupancy from the pointer pair.
  always_comb begin
    o_empty = (wr_q == rd_q);
    o_full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    o_rdata = o_empty ? '0 : mem_q[rd_q[AW-1:0]];
    o_level = LVLW'(wr_q - rd_q);
  end

  // A push into a full FIFO is only taken when the head is popped on the same edge.
  always_comb begin
    do_pop  = i_pop && !o_empty;
    do_push = i_push && (!o_full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = i_wdata;
      wr_d                = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/limber_gnrl_rand_pack.sv
// Samples the LFSR output every DECORR enabled cycles, packs LANES samples
// MSB-first into a word and queues completed words in a FWFT FIFO.
module limber_gnrl_rand_pack
  import limber_gnrl_rand_pack_pkg::*;
#(
  parameter int unsigned RAND_LEN   = 8,
  parameter int unsigned WORD_LEN   = 32,
  parameter int unsigned DECORR     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [RAND_LEN-1:0]             i_rand,
  input  logic                            i_seed_wen,
  input  logic                            i_en,
  input  logic                            i_clr,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [WORD_LEN-1:0]             o_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level,
  output logic                            o_drop
);

  localparam int unsigned LANES = lanes_f(WORD_LEN, RAND_LEN);
  localparam int unsigned CW    = width_f(DECORR);
  localparam int unsigned LW    = width_f(LANES);

  if (!pack_params_ok(RAND_LEN, WORD_LEN, DECORR, FIFO_DEPTH)) begin : g_bad_params
    $error("limber_gnrl_rand_pack: illegal parameter combination");
  end

  logic [CW-1:0]                cnt_q, cnt_d;
  logic [LW-1:0]                lane_q, lane_d;
  logic [WORD_LEN-1:0]          sr_q, sr_d;
  logic                         drop_q, drop_d;
  logic [WORD_LEN+RAND_LEN-1:0] sr_cat;
  logic                         sample;
  logic                         push;
  logic                         pop;
  logic                         fifo_full;
  logic                         fifo_empty;

  // Sample counter, lane counter and shift register; the completed word is
  // the shifted value itself, so it enters the FIFO on the same edge.
  always_comb begin
    cnt_d  = cnt_q;
    lane_d = lane_q;
    sr_d   = sr_q;
    push   = 1'b0;
    sr_cat = {sr_q, i_rand};
    sample = i_en && !i_seed_wen && (cnt_q == CW'(DECORR - 1));
    if (i_seed_wen) begin
      cnt_d  = '0;
      lane_d = '0;
      sr_d   = '0;
    end else if (i_en) begin
      if (sample) begin
        cnt_d = '0;
        sr_d  = sr_cat[WORD_LEN-1:0];
        if (lane_q == LW'(LANES - 1)) begin
          lane_d = '0;
          push   = 1'b1;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Sticky drop flag; a drop on the same edge as a clear takes priority.
  always_comb begin
    pop    = o_valid && i_ready;
    drop_d = drop_q;
    if (push && fifo_full && !pop) begin
      drop_d = 1'b1;
    end else if (i_clr) begin
      drop_d = 1'b0;
    end
  end

  // Packer state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      lane_q <= '0;
      sr_q   <= '0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lane_q <= lane_d;
      sr_q   <= sr_d;
      drop_q <= drop_d;
    end
  end

  limber_gnrl_fifo #(
    .WIDTH (WORD_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (sr_cat[WORD_LEN-1:0]),
    .i_pop   (pop),
    .o_rdata (o_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  // Output flags.
  always_comb begin
    o_valid = !fifo_empty;
    o_drop  = drop_q;
  end

endmodule

// File: tb/tb_limber_gnrl_rand_pack.sv
// Directed bench for the random-word packer (RAND_LEN=8, WORD_LEN=32,
// DECORR=8, FIFO_DEPTH=4).
module tb_limber_gnrl_rand_pack;

  logic        i_clk;
  logic        i_rst;
  logic [7:0]  i_rand;
  logic        i_seed_wen;
  logic        i_en;
  logic        i_clr;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [2:0]  o_level;
  logic        o_drop;

  int checks;
  int failures;

  limber_gnrl_rand_pack #(
    .RAND_LEN   (8),
    .WORD_LEN   (32),
    .DECORR     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rand     (i_rand),
    .i_seed_wen (i_seed_wen),
    .i_en       (i_en),
    .i_clr      (i_clr),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_level    (o_level),
    .o_drop     (o_drop)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] word;
    logic        rdy;
    logic        clr;
    int          pre_lvl;
    logic        exp_valid;
    logic [31:0] exp_data;
    int          exp_lvl;
    logic        exp_drop;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Runs one word from a cnt=0/lane=0 start. Byte k (MSB first) is presented
  // on the 8k-th enabled edge; optional enable gap inserted after gap_at
  // enabled edges. Checks that nothing is pushed before the final edge.
  task automatic run_word(input logic [31:0] w, input logic rdy, input logic clr,
                          input int pre_lvl, input int gap_at, input int gap_len);
    int n;
    int g;
    logic [31:0] wv;
    n  = 0;
    g  = 0;
    wv = w;
    while (n < 32) begin
      if (n == gap_at && g < gap_len) begin
        i_en   = 1'b0;
        i_rand = 8'h5A;
        g++;
      end else begin
        if (n == 31) chk("level_before_push", 32'(o_level), 32'(pre_lvl));
        i_en = 1'b1;
        n++;
        i_rand = ((n % 8) == 0) ? wv[8*(4 - n/8) +: 8] : 8'hEE;
        if (n == 32) begin
          i_ready = rdy;
          i_clr   = clr;
        end
      end
      tick();
    end
    i_ready = 1'b0;
    i_clr   = 1'b0;
    i_rand  = 8'h00;
  endtask

  // Pops the head with sampling disabled so the packer state does not move.
  task automatic pop_chk(input string name, input logic [31:0] exp);
    i_en = 1'b0;
    chk({name, "_valid"}, 32'(o_valid), 32'd1);
    chk({name, "_data"}, o_data, exp);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic chk_empty(input string name);
    chk({name, "_valid"}, 32'(o_valid), 32'd0);
    chk({name, "_data"}, o_data, 32'd0);
    chk({name, "_level"}, 32'(o_level), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    //            word          rdy   clr   pre valid data          lvl drop
    vecs[0] = '{32'h11223344, 1'b0, 1'b0, 0, 1'b1, 32'h11223344, 1, 1'b0};
    vecs[1] = '{32'hA1A2A3A4, 1'b0, 1'b0, 1, 1'b1, 32'h11223344, 2, 1'b0};
    vecs[2] = '{32'hB1B2B3B4, 1'b0, 1'b0, 2, 1'b1, 32'h11223344, 3, 1'b0};
    vecs[3] = '{32'hC1C2C3C4, 1'b0, 1'b0, 3, 1'b1, 32'h11223344, 4, 1'b0};
    vecs[4] = '{32'hD1D2D3D4, 1'b0, 1'b0, 4, 1'b1, 32'h11223344, 4, 1'b1};
    vecs[5] = '{32'hE1E2E3E4, 1'b1, 1'b1, 4, 1'b1, 32'hA1A2A3A4, 4, 1'b0};
    vecs[6] = '{32'hF1F2F3F4, 1'b0, 1'b1, 4, 1'b1, 32'hA1A2A3A4, 4, 1'b1};

    i_rst      = 1'b1;
    i_rand     = 8'h00;
    i_seed_wen = 1'b0;
    i_en       = 1'b0;
    i_clr      = 1'b0;
    i_ready    = 1'b0;
    #3;
    chk_empty("por");
    chk("por_drop", 32'(o_drop), 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();

    // Packing, overflow, full-with-pop and drop/clear priority.
    for (int i = 0; i < 7; i++) begin
      run_word(vecs[i].word, vecs[i].rdy, vecs[i].clr, vecs[i].pre_lvl, 99, 0);
      chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_data", i), o_data, vecs[i].exp_data);
      chk($sformatf("v%0d_level", i), 32'(o_level), 32'(vecs[i].exp_lvl));
      chk($sformatf("v%0d_drop", i), 32'(o_drop), 32'(vecs[i].exp_drop));
    end

    // Clear the sticky flag, then confirm the head is stable while not ready.
    i_en  = 1'b0;
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("clr_drop", 32'(o_drop), 32'd0);
    tick();
    tick();
    chk("hold_data", o_data, 32'hA1A2A3A4);
    chk("hold_level", 32'(o_level), 32'd4);

    pop_chk("drain0", 32'hA1A2A3A4);
    pop_chk("drain1", 32'hB1B2B3B4);
    pop_chk("drain2", 32'hC1C2C3C4);
    pop_chk("drain3", 32'hE1E2E3E4);
    chk_empty("drained");

    // Asynchronous reset mid-word with two words queued.
    run_word(32'h01020304, 1'b0, 1'b0, 0, 99, 0);
    run_word(32'h05060708, 1'b0, 1'b0, 1, 99, 0);
    i_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_rand = 8'h77;
      tick();
    end
    #2;
    i_rst = 1'b1;
    #1;
    chk_empty("async_rst");
    chk("async_rst_drop", 32'(o_drop), 32'd0);
    #1;
    i_rst = 1'b0;
    run_word(32'hDEADBEEF, 1'b0, 1'b0, 0, 99, 0);
    chk("post_rst_valid", 32'(o_valid), 32'd1);
    chk("post_rst_data", o_data, 32'hDEADBEEF);
    chk("post_rst_level", 32'(o_level), 32'd1);
    pop_chk("post_rst_pop", 32'hDEADBEEF);

    // Seed write partway through the third word.
    run_word(32'h01020304, 1'b0, 1'b0, 0, 99, 0);
    run_word(32'h05060708, 1'b0, 1'b0, 1, 99, 0);
    i_en = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      i_rand = (n == 8) ? 8'h55 : ((n == 16) ? 8'h66 : 8'hEE);
      tick();
    end
    i_seed_wen = 1'b1;
    i_rand     = 8'h99;
    tick();
    i_seed_wen = 1'b0;
    chk("seed_level", 32'(o_level), 32'd2);
    chk("seed_head", o_data, 32'h01020304);
    run_word(32'h71727374, 1'b0, 1'b0, 2, 99, 0);
    chk("seed_w3_level", 32'(o_level), 32'd3);
    pop_chk("seed_pop0", 32'h01020304);
    pop_chk("seed_pop1", 32'h05060708);
    pop_chk("seed_pop2", 32'h71727374);
    chk_empty("seed_done");

    // Enable gap of 5 cycles at cnt=3 stretches the word by exactly 5 edges.
    run_word(32'h9A9B9C9D, 1'b0, 1'b0, 0, 3, 5);
    chk("gap_valid", 32'(o_valid), 32'd1);
    chk("gap_data", o_data, 32'h9A9B9C9D);
    chk("gap_level", 32'(o_level), 32'd1);
    chk("gap_drop", 32'(o_drop), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
